// File: rtl/wide_bus_reader.sv
// Snapshots the wide d/e/f nets on start and streams them out as fixed-width
// slices over valid/ready, accumulating a rotate-XOR signature of the stream.
module wide_bus_reader #(
   parameter int SLICE_W = 30,
   parameter int D_W     = 900,
   parameter int E_W     = 10,
   parameter int F_W     = 5,
   localparam int TOT_W  = D_W + E_W + F_W,
   localparam int NSLICE = (TOT_W + SLICE_W - 1) / SLICE_W,
   localparam int IDX_W  = $clog2(NSLICE)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [D_W-1:0]     d,
   input  logic [E_W-1:0]     e,
   input  logic [F_W-1:0]     f,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SLICE_W-1:0] out_data,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_last,
   output logic [SLICE_W-1:0] sig,
   output logic               sig_valid
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_DONE
   } state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   state_e               state_q, state_d;
   logic [TOT_W-1:0]     snap_q, snap_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [SLICE_W-1:0]   sig_q, sig_d;
   logic [NSLICE*SLICE_W-1:0] snap_pad;
   logic                 accept;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign accept = (state_q == S_SEND) && out_ready;

   // NOTE: every variable assigned in an always_comb gets a default first, so
   // no path through the case/if leaves it unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_SEND;
         S_SEND: if (accept && idx_q == LAST_IDX) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      out_valid = (state_q == S_SEND);
      sig_valid = (state_q == S_DONE);
      out_last  = (state_q == S_SEND) && (idx_q == LAST_IDX);
   end

   // Zero-extend the snapshot so the top slice reads 0 above TOT_W-1.
   always_comb begin
      snap_pad              = '0;
      snap_pad[TOT_W-1:0]   = snap_q;
      out_data              = snap_pad[idx_q*SLICE_W +: SLICE_W];
   end

   assign out_idx = idx_q;
   assign sig     = sig_q;

   always_comb begin
      snap_d = snap_q;
      idx_d  = idx_q;
      sig_d  = sig_q;
      if (state_q == S_IDLE && start) begin
         snap_d = {f, e, d};
         idx_d  = '0;
         sig_d  = '0;
      end else if (accept) begin
         sig_d = {sig_q[SLICE_W-2:0], sig_q[SLICE_W-1]} ^ out_data;
         if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
      end
   end

   // NOTE: the snapshot is an ordinary flop bank rather than a RAM, so it can
   // and does take the asynchronous reset; a memory array would not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_q <= '0;
         idx_q  <= '0;
         sig_q  <= '0;
      end else begin
         snap_q <= snap_d;
         idx_q  <= idx_d;
         sig_q  <= sig_d;
      end
   end

endmodule

// File: tb/tb_wide_bus_reader.sv
// Bench for wide_bus_reader: directed table of snapshots, randomized streams
// with backpressure and input churn, start spam, and a mid-stream reset.
module tb_wide_bus_reader;

   localparam int SW = 30;
   localparam int DW = 900;
   localparam int EW = 10;
   localparam int FW = 5;
   localparam int TW = DW + EW + FW;
   localparam int NS = 31;
   localparam int BUDGET = 400;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] d;
   logic [EW-1:0] e;
   logic [FW-1:0] f;
   logic          busy;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_data;
   logic [4:0]    out_idx;
   logic          out_last;
   logic [SW-1:0] sig;
   logic          sig_valid;

   int n_vec = 0;
   int n_err = 0;

   wide_bus_reader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .d         (d),
      .e         (e),
      .f         (f),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .sig       (sig),
      .sig_valid (sig_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic [EW-1:0] e;
      logic [FW-1:0] f;
      logic [SW-1:0] s0;
      logic [SW-1:0] s30;
      logic [SW-1:0] sig;
   } vec_t;

   vec_t tbl[3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Slice k of the snapshot, with positions beyond the snapshot reading 0.
   function automatic logic [SW-1:0] model_slice(input logic [TW-1:0] s, input int k);
      logic [SW-1:0] r;
      r = '0;
      for (int b = 0; b < SW; b++)
         if (k * SW + b < TW) r[b] = s[k * SW + b];
      return r;
   endfunction

   function automatic logic [SW-1:0] model_rotl(input logic [SW-1:0] x);
      logic [SW:0] w;
      w = {1'b0, x} << 1;
      return w[SW-1:0] | SW'(x >> (SW - 1));
   endfunction

   function automatic logic [DW-1:0] rand_d();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / SW; i++) r[i*SW +: SW] = SW'($urandom);
      return r;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_data"}, 32'(out_data), 32'd0);
      check({tag, "_idx"}, 32'(out_idx), 32'd0);
      check({tag, "_last"}, 32'(out_last), 32'd0);
      check({tag, "_sig"}, 32'(sig), 32'd0);
      check({tag, "_sigv"}, 32'(sig_valid), 32'd0);
   endtask

   // Called at a negedge in IDLE. Issues start, then follows the stream.
   task automatic run_stream(input logic [DW-1:0] dv, input logic [EW-1:0] ev,
                             input logic [FW-1:0] fv, input int ready_pct,
                             input bit scramble, input bit spam,
                             output logic [SW-1:0] s0, output logic [SW-1:0] s30,
                             output logic [SW-1:0] fsig);
      logic [TW-1:0] snap;
      logic [SW-1:0] exp_sl[NS];
      logic [SW-1:0] msig;
      int k;
      int cyc;
      bit rdy;
      snap = {fv, ev, dv};
      for (int i = 0; i < NS; i++) exp_sl[i] = model_slice(snap, i);
      s0 = 'x;
      s30 = 'x;
      d = dv;
      e = ev;
      f = fv;
      start = 1'b1;
      out_ready = 1'b1;
      k = 0;
      cyc = 0;
      msig = '0;
      while (k < NS && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         start = spam ? 1'($urandom_range(1)) : 1'b0;
         if (scramble) begin
            d = rand_d();
            e = EW'($urandom);
            f = FW'($urandom);
         end
         check("send_busy", 32'(busy), 32'd1);
         check("send_valid", 32'(out_valid), 32'd1);
         check("send_idx", 32'(out_idx), 32'(k));
         check("send_data", 32'(out_data), 32'(exp_sl[k]));
         check("send_last", 32'(out_last), 32'(k == NS - 1));
         check("send_sigv", 32'(sig_valid), 32'd0);
         check("send_sig", 32'(sig), 32'(msig));
         if (ready_pct >= 100) check("slice_timing", 32'(cyc), 32'(k + 1));
         if (k == 0) s0 = out_data;
         if (k == NS - 1) s30 = out_data;
         rdy = ($urandom_range(99) < ready_pct);
         out_ready = rdy;
         if (rdy) begin
            msig = model_rotl(msig) ^ exp_sl[k];
            k++;
         end
      end
      if (k < NS) check("stream_timeout", 32'(k), 32'(NS));
      @(negedge clk);
      cyc++;
      check("done_sigv", 32'(sig_valid), 32'd1);
      check("done_busy", 32'(busy), 32'd1);
      check("done_valid", 32'(out_valid), 32'd0);
      check("done_sig", 32'(sig), 32'(msig));
      if (ready_pct >= 100) check("sigv_timing", 32'(cyc), 32'(NS + 1));
      fsig = sig;
      @(negedge clk);
      start = 1'b0;
      out_ready = $urandom_range(1) == 1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_sigv", 32'(sig_valid), 32'd0);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_sig", 32'(sig), 32'(msig));
      repeat (3) begin
         @(negedge clk);
         check("idle_hold_busy", 32'(busy), 32'd0);
         check("idle_hold_sig", 32'(sig), 32'(msig));
      end
   endtask

   initial begin
      logic [SW-1:0] s0, s30, fsig;
      logic [DW-1:0] one_d;

      one_d = '0;
      one_d[0] = 1'b1;
      tbl[0] = '{d: '0,    e: '0, f: '0,     s0: 30'h0, s30: 30'h0,    sig: 30'h0};
      tbl[1] = '{d: one_d, e: '0, f: '0,     s0: 30'h1, s30: 30'h0,    sig: 30'h1};
      tbl[2] = '{d: '0,    e: '0, f: 5'h1f,  s0: 30'h0, s30: 30'h7C00, sig: 30'h7C00};

      rst_n = 1'b0;
      start = 1'b0;
      d = '0;
      e = '0;
      f = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         run_stream(tbl[i].d, tbl[i].e, tbl[i].f, 100, 1'b0, 1'b0, s0, s30, fsig);
         check($sformatf("tbl%0d_slice0", i), 32'(s0), 32'(tbl[i].s0));
         check($sformatf("tbl%0d_slice30", i), 32'(s30), 32'(tbl[i].s30));
         check($sformatf("tbl%0d_sig", i), 32'(fsig), 32'(tbl[i].sig));
      end

      for (int i = 0; i < 4; i++)
         run_stream(rand_d(), EW'($urandom), FW'($urandom), 40 + 15 * i, 1'b1, 1'b0,
                    s0, s30, fsig);

      run_stream(rand_d(), EW'($urandom), FW'($urandom), 100, 1'b1, 1'b1, s0, s30, fsig);
      run_stream(rand_d(), EW'($urandom), FW'($urandom), 50, 1'b0, 1'b1, s0, s30, fsig);

      // Mid-stream asynchronous reset while slice 12 is presented.
      d = rand_d();
      e = EW'($urandom);
      f = FW'($urandom);
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      check("pre_reset_idx", 32'(out_idx), 32'd12);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      repeat (3) begin
         @(negedge clk);
         check("rst_hold_sigv", 32'(sig_valid), 32'd0);
         check("rst_hold_busy", 32'(busy), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("post_rst");
      run_stream(rand_d(), EW'($urandom), FW'($urandom), 100, 1'b1, 1'b0, s0, s30, fsig);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wide_bus_reader.md
# wide_bus_reader

Sink-side reader for the hierarchy test fabric's wide driven buses. The mid-level blocks drive the 900-bit `d`, 10-bit `e` and 5-bit `f` nets; this block consumes those nets as inputs. On request it snapshots all three, streams them out as fixed-width slices over a valid/ready handshake, and produces a rotate-XOR signature. It sits at root level alongside the mid blocks, giving the floorplanner a consumer of the wide nets and giving benches an observable checksum.

## Interface
- `SLICE_W`, 30, output slice width in bits
- `D_W`, 900, width of `d`
- `E_W`, 10, width of `e`
- `F_W`, 5, width of `f`
- Derived: `TOT_W = D_W+E_W+F_W` (915); `NSLICE = ceil(TOT_W/SLICE_W)` (31); `IDX_W = clog2(NSLICE)` (5)

- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  snapshot-and-stream request, single-cycle pulse
- `d`  in  D_W  wide data bus
- `e`  in  E_W  side bus
- `f`  in  F_W  side bus
- `busy`  out  1  high from capture until signature is presented
- `out_valid`  out  1  slice available
- `out_ready`  in  1  downstream accepts slice
- `out_data`  out  SLICE_W  current slice
- `out_idx`  out  IDX_W  index of current slice, 0..NSLICE-1
- `out_last`  out  1  current slice is index NSLICE-1
- `sig`  out  SLICE_W  running/final signature
- `sig_valid`  out  1  one-cycle pulse, final signature valid

## Operation
- Snapshot vector `snap[TOT_W-1:0] = {f, e, d}`; `d[0]` is snap bit 0.
- Slice k is `snap[k*SLICE_W +: SLICE_W]`; bits above `TOT_W-1` read as 0 (slice 30 = `{15'b0, f, e}`).
- FSM states:
  - IDLE: waits. If `start`, capture `snap`, clear `idx` and `sig`, go to SEND.
  - SEND: `out_valid=1`, `out_data`=slice `idx`. On `out_valid&&out_ready`: `sig <= rotl1(sig) ^ out_data`. If `idx==NSLICE-1`, go to DONE; otherwise `idx++`.
  - DONE: one cycle. `sig_valid=1`, `busy=1`, then return to IDLE.
- `busy` = (state != IDLE).
- `start` is ignored in SEND and DONE; the snapshot is not re-taken.
- `d`, `e` and `f` are sampled only on the accepted `start` edge. Later input changes do not affect the stream.
- `sig` holds its final value in IDLE until the next accepted `start` clears it.
- `out_data`, `out_idx` and `out_last` are registered or derived from registered state only, with no combinational path from `d`, `e` or `f`.

## Timing
- Reset values: state=IDLE, `busy=0`, `out_valid=0`, `out_data=0`, `out_idx=0`, `out_last=0`, `sig=0`, `sig_valid=0`, snapshot=0.
- Reset assertion mid-stream aborts immediately (asynchronous). No `sig_valid` pulse is generated. The first cycle after deassertion is IDLE.
- `start` sampled high in cycle N gives `out_valid=1` with slice 0 in N+1.
- With `out_ready` held high, one slice per cycle: slice k appears in cycle N+1+k, and the last slice appears in N+31.
- `sig_valid` pulses in the cycle after the last handshake (N+32 at full rate). `busy` falls the cycle after that.
- Backpressure: while `out_valid&&!out_ready`, `out_data`, `out_idx` and `out_last` hold stable and `sig` does not update.
- `out_valid` never drops in SEND without a handshake.
- Earliest accepted restart is `start` in the first IDLE cycle after DONE.

## Test plan
- Reset, then `start` with `d=0`, `e=0`, `f=0`, `out_ready=1` -> 31 slices of 0, `out_idx` 0..30, `out_last` only on 30, `sig_valid` at N+32 with `sig=0`.
- `d=900'h1`, `e=0`, `f=0`, `out_ready=1` -> slice0=30'h1, others 0; final `sig=30'h1` (30 rotations wrap the bit back to 0).
- `d=0`, `e=0`, `f=5'h1f` -> only slice30 nonzero = 30'h7C00; final `sig=30'h7C00`.
- Random `d`/`e`/`f`, `out_ready` toggled pseudo-randomly, inputs changed after `start` -> slices match the captured snapshot and stay stable during stalls; `sig` matches the reference model.
- `start` pulsed repeatedly during SEND and DONE -> ignored; exactly one stream of 31 slices and one `sig_valid`.
- `rst_n` asserted at slice 12 -> all outputs return to reset values asynchronously with no `sig_valid`; a fresh `start` then gives a complete, correct stream.
